// File: rtl/secded_write_arbiter.sv
// Round-robin write arbiter sharing one external SECDED encoder among NUM_REQ requesters.
// Optional build macro SECDED_ERR_INJECT_EN XORs err_inject into the captured codeword.
module secded_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int SRC_W   = 2,
   parameter int ADDR_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*64-1:0]   req_data,
   output logic [63:0]             enc_data,
   input  logic [71:0]             enc_code,
   output logic                    mem_valid,
   input  logic                    mem_ready,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [71:0]             mem_code,
   output logic [SRC_W-1:0]        mem_src,
   output logic [15:0]             wr_count,
   input  logic [71:0]             err_inject
);

   localparam int CW = SRC_W + 1;

   typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

   state_t            state, state_next;
   logic [SRC_W-1:0]  rr_ptr;
   logic [SRC_W-1:0]  grant_idx;
   logic              grant_any;
   logic [CW-1:0]     cand;
   logic [63:0]       data_q;
   logic [63:0]       sel_data;
   logic [ADDR_W-1:0] sel_addr;
   logic [71:0]       code_in;
   logic              accept;
   logic              handshake;

`ifdef SECDED_ERR_INJECT_EN
   assign code_in = enc_code ^ err_inject;
`else
   logic unused_inject;
   assign unused_inject = ^err_inject;
   assign code_in = enc_code;
`endif

   // Search upward from rr_ptr, wrapping at NUM_REQ; cand never exceeds 2*NUM_REQ-2.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + CW'(k);
         if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
         if (!grant_any && req_valid[cand[SRC_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[SRC_W-1:0];
         end
      end
   end

   assign accept    = (state == IDLE) && grant_any;
   assign handshake = (state == HOLD) && mem_ready;
   assign enc_data  = data_q;

   always_comb begin
      sel_data  = '0;
      sel_addr  = '0;
      req_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == SRC_W'(k)) begin
            sel_data     = req_data[k*64 +: 64];
            sel_addr     = req_addr[k*ADDR_W +: ADDR_W];
            req_ready[k] = accept;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_any) state_next = ENCODE;
         ENCODE:  state_next = HOLD;
         HOLD:    if (mem_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The encoder is combinational, so enc_code is valid one cycle after data_q loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         data_q    <= '0;
         mem_addr  <= '0;
         mem_src   <= '0;
         mem_code  <= '0;
         mem_valid <= 1'b0;
         wr_count  <= '0;
      end else begin
         if (accept) begin
            data_q   <= sel_data;
            mem_addr <= sel_addr;
            mem_src  <= grant_idx;
         end
         if (state == ENCODE) begin
            mem_code  <= code_in;
            mem_valid <= 1'b1;
         end
         if (handshake) begin
            mem_valid <= 1'b0;
            rr_ptr    <= (mem_src == SRC_W'(NUM_REQ - 1)) ? '0 : mem_src + 1'b1;
            wr_count  <= wr_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_secded_write_arbiter.sv
// Randomized self-checking bench for secded_write_arbiter with a reference Hamming(72,64) encoder model.
// Define SECDED_ERR_INJECT_EN for both bench and RTL to exercise the fault-injection build.
module tb_secded_write_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int SW = 2;
`ifdef SECDED_ERR_INJECT_EN
   localparam bit INJ = 1'b1;
`else
   localparam bit INJ = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*64-1:0] req_data;
   logic [63:0]     enc_data;
   logic [71:0]     enc_code, mem_code, err_inject;
   logic            mem_valid, mem_ready;
   logic [AW-1:0]   mem_addr;
   logic [SW-1:0]   mem_src;
   logic [15:0]     wr_count;

   int passed = 0;
   int total = 0;
   int model_ptr = 0;
   int model_count = 0;
   int cyc = 0;
   logic [63:0]   mdata [N];
   logic [AW-1:0] maddr [N];

   secded_write_arbiter #(.NUM_REQ(N), .SRC_W(SW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .enc_data(enc_data), .enc_code(enc_code),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_code(mem_code),
      .mem_src(mem_src), .wr_count(wr_count), .err_inject(err_inject)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Extended Hamming: positions 1..71 at bits 1..71, parity at powers of two, overall parity at bit 0.
   function automatic logic [71:0] ref_encode(input logic [63:0] d);
      logic [71:0] c;
      logic        par;
      int          di;
      c  = '0;
      di = 0;
      for (int p = 1; p < 72; p++)
         if ((p & (p - 1)) != 0) begin
            c[p] = d[di];
            di++;
         end
      for (int k = 0; k < 7; k++) begin
         par = 1'b0;
         for (int p = 1; p < 72; p++)
            if (((p >> k) & 1) == 1) par = par ^ c[p];
         c[1 << k] = par;
      end
      c[0] = ^c[71:1];
      return c;
   endfunction

   assign enc_code = ref_encode(enc_data);

   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return 0;
   endfunction

   task automatic pack_inputs();
      for (int i = 0; i < N; i++) begin
         req_data[i*64 +: 64] = mdata[i];
         req_addr[i*AW +: AW] = maddr[i];
      end
   endtask

   task automatic randomize_words();
      for (int i = 0; i < N; i++) begin
         mdata[i] = {$urandom, $urandom};
         maddr[i] = AW'($urandom);
      end
      pack_inputs();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      req_valid  = '0;
      mem_ready  = 1'b1;
      err_inject = '0;
      randomize_words();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #12;
      total++;
      if ({req_ready, mem_valid, mem_src, mem_addr} !== '0)
         $display("[TB] FAIL reset_ctrl: got ready=%b valid=%b src=%0d addr=%h want all 0", req_ready, mem_valid, mem_src, mem_addr);
      else passed++;
      total++;
      if ({mem_code, enc_data, wr_count} !== '0)
         $display("[TB] FAIL reset_data: got code=%h enc=%h cnt=%0d want all 0", mem_code, enc_data, wr_count);
      else passed++;
      @(negedge clk) rst_n = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      total++;
      if ({mem_valid, wr_count} !== 17'd0)
         $display("[TB] FAIL idle_mem_ready_ignored: got valid=%b cnt=%0d want 0/0", mem_valid, wr_count);
      else passed++;
      tick();
   endtask

   task automatic test_single_req0();
      mdata[0] = 64'h0;
      maddr[0] = 16'h0010;
      pack_inputs();
      req_valid = 4'b0001;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) $display("[TB] FAIL req0_ready: got %b want 0001", req_ready);
      else passed++;
      tick();
      req_valid = '0;
      @(negedge clk);
      total++;
      if ({req_ready, mem_valid} !== 5'b0) $display("[TB] FAIL req0_encode: got ready=%b valid=%b want 0/0", req_ready, mem_valid);
      else passed++;
      tick();
      @(negedge clk);
      total++;
      if ({mem_valid, mem_src, mem_addr, mem_code} !== {1'b1, 2'd0, 16'h0010, 72'h0})
         $display("[TB] FAIL req0_write: got v=%b src=%0d addr=%h code=%h want 1/0/0010/0", mem_valid, mem_src, mem_addr, mem_code);
      else passed++;
      tick();
      @(negedge clk);
      total++;
      if ({mem_valid, wr_count} !== {1'b0, 16'd1})
         $display("[TB] FAIL req0_done: got v=%b cnt=%0d want 0/1", mem_valid, wr_count);
      else passed++;
      model_ptr = 1;
      model_count = 1;
      tick();
   endtask

   task automatic test_req2();
      mdata[2] = 64'h1;
      maddr[2] = AW'($urandom);
      pack_inputs();
      req_valid = 4'b0100;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0100) $display("[TB] FAIL req2_ready: got %b want 0100", req_ready);
      else passed++;
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      total++;
      if ({mem_valid, mem_src, mem_addr, mem_code} !== {1'b1, 2'd2, maddr[2], 72'hF})
         $display("[TB] FAIL req2_write: got v=%b src=%0d addr=%h code=%h want 1/2/%h/f", mem_valid, mem_src, mem_addr, mem_code, maddr[2]);
      else passed++;
      tick();
      model_ptr = 3;
      model_count = 2;
      @(negedge clk);
      total++;
      if (wr_count !== 16'd2) $display("[TB] FAIL req2_count: got %0d want 2", wr_count);
      else passed++;
      tick();
   endtask

   task automatic test_err_inject();
      logic [71:0] exp;
      exp = INJ ? 72'h1 : 72'h0;
      mdata[3] = 64'h0;
      pack_inputs();
      err_inject = 72'h1;
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      total++;
      if ({mem_valid, mem_src, mem_code} !== {1'b1, 2'd3, exp})
         $display("[TB] FAIL err_inject: got v=%b src=%0d code=%h want 1/3/%h", mem_valid, mem_src, mem_code, exp);
      else passed++;
      tick();
      err_inject = '0;
      model_ptr = 0;
      model_count = 3;
   endtask

   task automatic test_reset_in_hold();
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, 15));
      randomize_words();
      mem_ready = 1'b0;
      req_valid = mask;
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      total++;
      if (mem_valid !== 1'b1) $display("[TB] FAIL rst_hold_reached: got v=%b want 1", mem_valid);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({req_ready, mem_valid, mem_src, mem_addr, mem_code, enc_data, wr_count} !== '0)
         $display("[TB] FAIL rst_hold_async: got v=%b src=%0d addr=%h code=%h enc=%h cnt=%0d want all 0", mem_valid, mem_src, mem_addr, mem_code, enc_data, wr_count);
      else passed++;
      mem_ready = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      model_ptr = 0;
      model_count = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         @(negedge clk);
         total++;
         if ({mem_valid, wr_count} !== 17'd0)
            $display("[TB] FAIL rst_no_write: got v=%b cnt=%0d want 0/0", mem_valid, wr_count);
         else passed++;
      end
      tick();
   endtask

   task automatic test_round_robin();
      int w;
      int last;
      last = 0;
      randomize_words();
      mem_ready = 1'b1;
      req_valid = '1;
      for (int g = 0; g < 8; g++) begin
         w = rr_pick('1, model_ptr);
         @(negedge clk);
         total++;
         if (req_ready !== N'(1 << w)) $display("[TB] FAIL rr_grant%0d: got %b want one-hot %0d", g, req_ready, w);
         else passed++;
         tick();
         tick();
         @(negedge clk);
         total++;
         if ({mem_valid, mem_src, mem_addr, mem_code} !== {1'b1, SW'(w), maddr[w], ref_encode(mdata[w])})
            $display("[TB] FAIL rr_write%0d: got src=%0d addr=%h code=%h want src=%0d", g, mem_src, mem_addr, mem_code, w);
         else passed++;
         if (g > 0) begin
            total++;
            if (cyc - last !== 3) $display("[TB] FAIL rr_interval%0d: got %0d cycles want 3", g, cyc - last);
            else passed++;
         end
         last = cyc;
         tick();
         model_ptr = (w + 1) % N;
         model_count++;
      end
      req_valid = '0;
      @(negedge clk);
      total++;
      if (wr_count !== 16'(model_count)) $display("[TB] FAIL rr_count: got %0d want %0d", wr_count, model_count);
      else passed++;
      tick();
   endtask

   task automatic test_backpressure();
      logic [N-1:0] mask;
      logic [90:0]  exp;
      int w;
      mask = N'($urandom_range(1, 15));
      randomize_words();
      w = rr_pick(mask, model_ptr);
      exp = {1'b1, SW'(w), maddr[w], ref_encode(mdata[w])};
      mem_ready = 1'b0;
      req_valid = mask;
      tick();
      randomize_words();
      req_valid = '1;
      tick();
      for (int s = 0; s < 10; s++) begin
         @(negedge clk);
         total++;
         if ({mem_valid, mem_src, mem_addr, mem_code} !== exp)
            $display("[TB] FAIL bp_hold%0d: got v=%b src=%0d addr=%h code=%h want %h", s, mem_valid, mem_src, mem_addr, mem_code, exp);
         else passed++;
         total++;
         if (req_ready !== '0) $display("[TB] FAIL bp_ready%0d: got %b want 0000", s, req_ready);
         else passed++;
         tick();
      end
      mem_ready = 1'b1;
      req_valid = '0;
      tick();
      model_ptr = (w + 1) % N;
      model_count++;
      @(negedge clk);
      total++;
      if ({mem_valid, wr_count} !== {1'b0, 16'(model_count)})
         $display("[TB] FAIL bp_release: got v=%b cnt=%0d want 0/%0d", mem_valid, wr_count, model_count);
      else passed++;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0]  mask;
      logic [63:0]   ed;
      logic [AW-1:0] ea;
      logic [71:0]   ecode;
      int w;
      int stall;
      for (int it = 0; it < 40; it++) begin
         randomize_words();
         err_inject = {8'($urandom), $urandom, $urandom};
         mask  = N'($urandom_range(0, 15));
         stall = $urandom_range(0, 3);
         w     = rr_pick(mask, model_ptr);
         req_valid = mask;
         @(negedge clk);
         total++;
         if (req_ready !== ((mask == 0) ? '0 : N'(1 << w)))
            $display("[TB] FAIL rand_ready%0d: got %b mask %b ptr %0d", it, req_ready, mask, model_ptr);
         else passed++;
         total++;
         if (wr_count !== 16'(model_count)) $display("[TB] FAIL rand_count%0d: got %0d want %0d", it, wr_count, model_count);
         else passed++;
         if (mask == 0) begin
            tick();
            continue;
         end
         ed = mdata[w];
         ea = maddr[w];
         ecode = ref_encode(ed) ^ (INJ ? err_inject : 72'h0);
         tick();
         req_valid = '0;
         randomize_words();
         mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         total++;
         if ({enc_data, mem_valid} !== {ed, 1'b0})
            $display("[TB] FAIL rand_encode%0d: got enc=%h v=%b want %h/0", it, enc_data, mem_valid, ed);
         else passed++;
         tick();
         for (int s = 0; s <= stall; s++) begin
            mem_ready = (s == stall);
            @(negedge clk);
            total++;
            if ({mem_valid, mem_src, mem_addr, mem_code} !== {1'b1, SW'(w), ea, ecode})
               $display("[TB] FAIL rand_write%0d: got src=%0d addr=%h code=%h want src=%0d addr=%h code=%h", it, mem_src, mem_addr, mem_code, w, ea, ecode);
            else passed++;
            tick();
         end
         model_ptr = (w + 1) % N;
         model_count++;
      end
      err_inject = '0;
      @(negedge clk);
      total++;
      if ({mem_valid, wr_count} !== {1'b0, 16'(model_count)})
         $display("[TB] FAIL rand_final: got v=%b cnt=%0d want 0/%0d", mem_valid, wr_count, model_count);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_req0();
      test_req2();
      test_err_inject();
      test_reset_in_hold();
      test_round_robin();
      test_backpressure();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/secded_write_arbiter.md
Name: secded_write_arbiter

Overview:
- Shares one secded_encoder_72_64 instance among NUM_REQ write requesters. Round-robin arbitration.
- Latches the winner's address and data, then drives the 64-bit word to the external encoder.
- Registers the 72-bit codeword and presents it on a valid/ready memory write port.
- Sits between the ECC-protected memory's client ports and its write port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SRC_W, 2, width of the source-index field; must satisfy 2**SRC_W >= NUM_REQ.
- ADDR_W, 16, memory word address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  one-hot accept pulse.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*64  packed data; requester i occupies [i*64 +: 64].
- enc_data  output  64  word driven to the encoder's data_in.
- enc_code  input  72  codeword from the encoder's code_out (combinational).
- mem_valid  output  1  codeword write pending.
- mem_ready  input  1  memory accepts the write.
- mem_addr  output  ADDR_W  write address.
- mem_code  output  72  registered codeword.
- mem_src  output  SRC_W  index of the granted requester.
- wr_count  output  16  completed-write counter.
- err_inject  input  72  XOR mask (used only when SECDED_ERR_INJECT_EN is defined).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, mem_valid=0.
  - mem_addr=0, mem_code=0, mem_src=0, enc_data=0, wr_count=0.
  - A reset mid-transaction drops the in-flight word; no partial write is issued.
- FSM states: IDLE, ENCODE, HOLD.
- IDLE:
  - If any req_valid is set, grant the first requester i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NUM_REQ.
  - req_ready[i] is combinational in IDLE. It equals the grant, so it is high in the same cycle as req_valid and is qualified by it.
  - On that edge: data register <= req_data[i], mem_addr <= req_addr[i], mem_src <= i. Go to ENCODE.
  - If no req_valid is set, stay in IDLE.
- req_ready is 0 in every state except IDLE. At most one bit is high.
- ENCODE:
  - enc_data is the data register; it is stable from the accept edge onward.
  - One edge later: mem_code <= enc_code, mem_valid <= 1. Go to HOLD.
- HOLD:
  - mem_valid, mem_addr, mem_code and mem_src are held stable until mem_ready=1.
  - On the handshake edge: mem_valid <= 0, rr_ptr <= (mem_src+1) mod NUM_REQ, wr_count <= wr_count+1 (wraps 0xFFFF->0). Go to IDLE.
- Latency and throughput:
  - Accept at edge T gives mem_valid=1 after edge T+1.
  - The minimum issue interval is 3 cycles per write.
- Requester rules:
  - A requester may drop req_valid before it is granted without penalty.
  - Requests arriving during ENCODE/HOLD wait; there is no queueing beyond each requester's own valid.
- mem_ready while mem_valid=0 is ignored.
- Fairness: a requester that keeps req_valid high is granted within NUM_REQ grants.

Optional Feature:
- Macro: SECDED_ERR_INJECT_EN.
- When defined, the ENCODE capture is mem_code <= enc_code ^ err_inject, for fault-injection testing of the downstream decoder.
- When undefined, err_inject is unused and mem_code <= enc_code exactly.

Test Plan:
- Requester 0 writes data=0x0000000000000000, addr=0x0010, mem_ready=1:
  - req_ready=4'b0001 in the request cycle.
  - mem_valid high 2 cycles later with mem_code=72'h0, mem_addr=0x0010, mem_src=0; wr_count=1 after the handshake.
- Requester 2 writes data=0x0000000000000001:
  - mem_code=72'h00000000000000000F (bits 3,2,1,0 set), mem_src=2.
- All four requesters hold req_valid with mem_ready=1:
  - Grant order is 0,1,2,3,0,... with a new mem_valid every 3 cycles.
- Backpressure: mem_ready=0 for 10 cycles during HOLD:
  - mem_valid, mem_code and mem_addr stay unchanged.
  - req_ready stays 0 for all requesters.
  - The handshake completes on the first cycle mem_ready=1.
- rst_n pulsed low during HOLD:
  - All outputs return to reset values asynchronously; no write is issued.
  - Next grant comes from rr_ptr=0.
- With SECDED_ERR_INJECT_EN defined, err_inject=72'h1, data=0:
  - mem_code=72'h000000000000000001.
  - With err_inject=0, output is identical to the undefined build.
